// File: rtl/sync_fifo_wrctrl_if.sv
// Write-side bundle between the producer/read controller and the FIFO write controller.
interface sync_fifo_wrctrl_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
);
  logic          wenable;
  logic [DW-1:0] wdata_i;
  logic [AW-1:0] rpnt_i;
  logic          ovf_clr;

  logic          wenable_o;
  logic [DW-1:0] wdata_o;
  logic [AW-1:0] wpnt_o;
  logic          full_o;
  logic          afull_o;
  logic [AW-1:0] level_o;
  logic          ovf_o;
  logic [7:0]    drop_cnt_o;

  modport master (
    output wenable, wdata_i, rpnt_i, ovf_clr,
    input  wenable_o, wdata_o, wpnt_o, full_o, afull_o, level_o, ovf_o, drop_cnt_o
  );

  modport slave (
    input  wenable, wdata_i, rpnt_i, ovf_clr,
    output wenable_o, wdata_o, wpnt_o, full_o, afull_o, level_o, ovf_o, drop_cnt_o
  );
endinterface

// File: rtl/sync_fifo_wrctrl.sv
// Synchronous FIFO write controller: write pointer, full/almost-full/level status,
// and sticky overflow tracking with a saturating dropped-write counter.
module sync_fifo_wrctrl #(
  parameter int unsigned AW     = 7,
  parameter int unsigned DW     = 32,
  parameter int unsigned AF_LVL = 4
) (
  input logic              wclk_i,
  input logic              rst_n,
  sync_fifo_wrctrl_if.slave wr_if
);

  localparam int unsigned      DCW      = 8;
  localparam logic [DCW-1:0]   DROP_MAX = {DCW{1'b1}};
  localparam logic [AW-1:0]    CAP      = {AW{1'b1}};
  localparam logic [AW-1:0]    AF_THR   = AW'(AF_LVL);

  logic [AW-1:0]  wpnt_q;
  logic           ovf_q;
  logic [DCW-1:0] drop_q;

  logic [AW-1:0]  wpnt_inc_c;
  logic [AW-1:0]  level_c;
  logic [AW-1:0]  free_c;
  logic           full_c;
  logic           afull_c;
  logic           accept_c;
  logic           reject_c;
  logic [DW-1:0]  wdata_c;

  logic [AW-1:0]  wpnt_d;
  logic           ovf_d;
  logic [DCW-1:0] drop_d;

  // Status: one slot stays unused so wpnt==rpnt unambiguously means empty.
  always_comb begin
    wpnt_inc_c = wpnt_q + AW'(1);
    level_c    = wpnt_q - wr_if.rpnt_i;
    free_c     = CAP - level_c;
    full_c     = (wpnt_inc_c == wr_if.rpnt_i);
    afull_c    = (free_c <= AF_THR);
    accept_c   = rst_n & wr_if.wenable & ~full_c;
    reject_c   = rst_n & wr_if.wenable &  full_c;
    wdata_c    = wr_if.wdata_i;
  end

  // Next state; clear wins over a coincident rejected write.
  always_comb begin
    wpnt_d = wpnt_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (accept_c) begin
      wpnt_d = wpnt_inc_c;
    end
    if (wr_if.ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (reject_c) begin
      ovf_d = 1'b1;
      if (drop_q != DROP_MAX) begin
        drop_d = drop_q + DCW'(1);
      end
    end
  end

  always_ff @(posedge wclk_i or negedge rst_n) begin
    if (!rst_n) begin
      wpnt_q <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wpnt_q <= wpnt_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign wr_if.wenable_o  = accept_c;
  assign wr_if.wdata_o    = wdata_c;
  assign wr_if.wpnt_o     = wpnt_q;
  assign wr_if.full_o     = full_c;
  assign wr_if.afull_o    = afull_c;
  assign wr_if.level_o    = level_c;
  assign wr_if.ovf_o      = ovf_q;
  assign wr_if.drop_cnt_o = drop_q;

endmodule

// File: tb/tb_sync_fifo_wrctrl.sv
// Bench for sync_fifo_wrctrl: directed scenarios plus random traffic against an
// occupancy-arithmetic reference model.
module tb_sync_fifo_wrctrl;

  localparam int unsigned AW     = 3;
  localparam int unsigned DW     = 16;
  localparam int unsigned AF_LVL = 2;
  localparam int          DEPTH  = 8;
  localparam int          CAP    = DEPTH - 1;

  logic wclk_i = 1'b0;
  logic rst_n;

  sync_fifo_wrctrl_if #(.AW(AW), .DW(DW)) wr_if ();

  sync_fifo_wrctrl #(.AW(AW), .DW(DW), .AF_LVL(AF_LVL)) dut (
    .wclk_i (wclk_i),
    .rst_n  (rst_n),
    .wr_if  (wr_if)
  );

  always #5 wclk_i = ~wclk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: write count position, read position, overflow bookkeeping.
  int m_wp   = 0;
  int rp     = 0;
  bit m_ovf  = 1'b0;
  int m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wp   = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One clock cycle, starting and ending just after a falling edge.
  task automatic step(input bit we, input bit clr);
    logic [DW-1:0] wd;
    int exp_level;
    bit exp_full, exp_afull, exp_acc, exp_rej;
    wd = DW'($urandom);
    wr_if.wenable = we;
    wr_if.wdata_i = wd;
    wr_if.rpnt_i  = AW'(rp);
    wr_if.ovf_clr = clr;
    #1;
    exp_level = (m_wp - rp + DEPTH) % DEPTH;
    exp_full  = (((m_wp + 1) % DEPTH) == rp);
    exp_afull = ((CAP - exp_level) <= int'(AF_LVL));
    exp_acc   = rst_n && we && !exp_full;
    exp_rej   = rst_n && we && exp_full;
    chk("wpnt",    32'(wr_if.wpnt_o),     32'(m_wp));
    chk("wen",     32'(wr_if.wenable_o),  32'(exp_acc));
    chk("wdata",   32'(wr_if.wdata_o),    32'(wd));
    chk("full",    32'(wr_if.full_o),     32'(exp_full));
    chk("afull",   32'(wr_if.afull_o),    32'(exp_afull));
    chk("level",   32'(wr_if.level_o),    32'(exp_level));
    chk("ovf",     32'(wr_if.ovf_o),      32'(m_ovf));
    chk("drop",    32'(wr_if.drop_cnt_o), 32'(m_drop));
    @(posedge wclk_i);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (exp_acc) m_wp = (m_wp + 1) % DEPTH;
      if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end else if (exp_rej) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
    @(negedge wclk_i);
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_if.wenable = 1'b1;
    wr_if.wdata_i = '0;
    wr_if.rpnt_i  = '0;
    wr_if.ovf_clr = 1'b0;
    #2;
    chk("rst_wpnt",  32'(wr_if.wpnt_o),     0);
    chk("rst_wen",   32'(wr_if.wenable_o),  0);
    chk("rst_ovf",   32'(wr_if.ovf_o),      0);
    chk("rst_drop",  32'(wr_if.drop_cnt_o), 0);
    chk("rst_full",  32'(wr_if.full_o),     0);
    chk("rst_afull", 32'(wr_if.afull_o),    0);
    chk("rst_level", 32'(wr_if.level_o),    0);
    @(negedge wclk_i);
    rst_n = 1'b1;
    model_reset();

    // Fill an empty FIFO to capacity.
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0);
      if (i == 4) chk("fill_afull4", 32'(wr_if.afull_o), 0);
      if (i == 5) chk("fill_afull5", 32'(wr_if.afull_o), 1);
    end
    chk("fill_wpnt7", 32'(wr_if.wpnt_o),    7);
    chk("fill_full",  32'(wr_if.full_o),    1);
    chk("fill_wen8",  32'(wr_if.wenable_o), 0);

    // Overflow while full, then clear.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("ovf_set",  32'(wr_if.ovf_o),      1);
    chk("ovf_drop", 32'(wr_if.drop_cnt_o), 3);
    chk("ovf_wpnt", 32'(wr_if.wpnt_o),     7);
    step(1'b0, 1'b1);
    chk("clr_ovf",  32'(wr_if.ovf_o),      0);
    chk("clr_drop", 32'(wr_if.drop_cnt_o), 0);

    // Read and write coinciding while full: write must still be rejected.
    rp = 5;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("rw_wpnt4", 32'(wr_if.wpnt_o), 4);
    chk("rw_full",  32'(wr_if.full_o), 1);
    step(1'b1, 1'b0);
    rp = 6;
    chk("rw_hold", 32'(wr_if.wpnt_o), 4);
    wr_if.rpnt_i = AW'(rp);
    #1;
    chk("rw_unfull", 32'(wr_if.full_o),    0);
    chk("rw_accept", 32'(wr_if.wenable_o), 1);
    step(1'b1, 1'b0);
    chk("rw_wpnt5", 32'(wr_if.wpnt_o), 5);

    // Drain to level 1, then write+read together keeps the level.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      rp = (rp + 1) % DEPTH;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      rp = (rp + 1) % DEPTH;
      wr_if.rpnt_i = AW'(rp);
      #1;
      chk("wr_rd_level", 32'(wr_if.level_o), 1);
    end

    // Pointer wrap.
    chk("wrap_pre", 32'(wr_if.wpnt_o), 7);
    step(1'b1, 1'b0);
    chk("wrap_wpnt0",  32'(wr_if.wpnt_o),  0);
    chk("wrap_level2", 32'(wr_if.level_o), 2);
    step(1'b1, 1'b0);
    chk("wrap_wpnt1",  32'(wr_if.wpnt_o),  1);
    chk("wrap_level3", 32'(wr_if.level_o), 3);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("burst_wpnt3", 32'(wr_if.wpnt_o), 3);
    wr_if.wenable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wpnt", 32'(wr_if.wpnt_o),    0);
    chk("arst_wen",  32'(wr_if.wenable_o), 0);
    @(posedge wclk_i);
    #1 chk("arst_wen_edge", 32'(wr_if.wenable_o), 0);
    @(negedge wclk_i);
    model_reset();
    rp = 0;
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("first_after_rst", 32'(wr_if.wpnt_o), 1);

    // Drop counter saturation, then clear beats a coincident rejected write.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("sat_full", 32'(wr_if.full_o), 1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0);
    chk("sat_drop", 32'(wr_if.drop_cnt_o), 255);
    step(1'b1, 1'b1);
    chk("sat_clr_drop", 32'(wr_if.drop_cnt_o), 0);
    chk("sat_clr_ovf",  32'(wr_if.ovf_o),      0);

    // Random traffic; the reader only advances over occupied slots.
    for (int i = 0; i < 3000; i++) begin
      bit we, rd, clr;
      int wp_before;
      we  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 31) == 0);
      wp_before = m_wp;
      step(we, clr);
      if (rd && (rp != wp_before)) rp = (rp + 1) % DEPTH;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
